// File: rtl/dcache_assoc.sv
// Set-associative write-through data cache between the MEM stage and the memory controller.
// Round-robin replacement, byte-enable stores, request/response handshakes on both sides.
module dcache_assoc #(
  parameter int SETS   = 64,
  parameter int WAYS   = 2,
  parameter int TAG_HI = 17
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        flush_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [3:0]  req_be_i,
  output logic        resp_valid_o,
  output logic [31:0] resp_data_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_be_o,
  input  logic        mem_done_i,
  input  logic [31:0] mem_rdata_i
);

  localparam int IDX_W = $clog2(SETS);
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int TAG_W = TAG_HI - IDX_W - 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOOKUP = 3'd1,
    S_MISS   = 3'd2,
    S_STORE  = 3'd3,
    S_RESP   = 3'd4
  } state_t;

  state_t             r_state;
  logic [31:2]        r_addr;
  logic               r_we;
  logic [31:0]        r_wdata;
  logic [3:0]         r_be;
  logic [31:0]        r_resp_data;

  logic               r_valid [SETS][WAYS];
  logic [TAG_W-1:0]   r_tag   [SETS][WAYS];
  logic [31:0]        r_data  [SETS][WAYS];
  logic [WAY_W-1:0]   r_rr    [SETS];

  logic [IDX_W-1:0]   w_idx;
  logic [TAG_W-1:0]   w_tag;
  logic               w_hit;
  logic [WAY_W-1:0]   w_hit_way;
  logic               w_has_inv;
  logic [WAY_W-1:0]   w_inv_way;
  logic [WAY_W-1:0]   w_rr_cur;
  logic [WAY_W-1:0]   w_rr_next;
  logic [WAY_W-1:0]   w_victim;
  logic               w_unused_addr_lsb;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  be);
    logic [31:0] res;
    res = old_w;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) res[8*b +: 8] = new_w[8*b +: 8];
    end
    return res;
  endfunction

  assign w_unused_addr_lsb = ^req_addr_i[1:0];
  assign w_idx    = r_addr[IDX_W+1:2];
  assign w_tag    = r_addr[TAG_HI:IDX_W+2];
  assign w_rr_cur = r_rr[w_idx];

  // Tag match and victim selection on the latched set; scanning downward leaves the lowest invalid way.
  always_comb begin
    w_hit     = 1'b0;
    w_hit_way = '0;
    w_has_inv = 1'b0;
    w_inv_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (r_valid[w_idx][w] && (r_tag[w_idx][w] == w_tag)) begin
        w_hit     = 1'b1;
        w_hit_way = WAY_W'(w);
      end
      if (!r_valid[w_idx][w]) begin
        w_has_inv = 1'b1;
        w_inv_way = WAY_W'(w);
      end
    end
    if (WAYS == 1) begin
      w_rr_next = '0;
    end else begin
      w_rr_next = w_rr_cur + WAY_W'(1);
    end
    w_victim = w_has_inv ? w_inv_way : w_rr_cur;
  end

  // Control FSM, request latches, response data and the tag/data arrays.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_we        <= 1'b0;
      r_wdata     <= 32'h0000_0000;
      r_be        <= 4'h0;
      r_resp_data <= 32'h0000_0000;
      for (int s = 0; s < SETS; s++) begin
        r_rr[s] <= '0;
        for (int w = 0; w < WAYS; w++) r_valid[s][w] <= 1'b0;
      end
    end else if (rdy) begin
      case (r_state)
        S_IDLE: begin
          if (flush_i) begin
            for (int s = 0; s < SETS; s++) begin
              r_rr[s] <= '0;
              for (int w = 0; w < WAYS; w++) r_valid[s][w] <= 1'b0;
            end
          end else if (req_valid_i) begin
            r_addr  <= req_addr_i[31:2];
            r_we    <= req_we_i;
            r_wdata <= req_wdata_i;
            r_be    <= req_be_i;
            r_state <= S_LOOKUP;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_LOOKUP: begin
          if (r_we) begin
            r_state <= S_STORE;
          end else if (w_hit) begin
            r_resp_data <= r_data[w_idx][w_hit_way];
            r_state     <= S_RESP;
          end else begin
            r_state <= S_MISS;
          end
        end
        S_MISS: begin
          if (mem_done_i) begin
            r_valid[w_idx][w_victim] <= 1'b1;
            r_tag[w_idx][w_victim]   <= w_tag;
            r_data[w_idx][w_victim]  <= mem_rdata_i;
            if (!w_has_inv) r_rr[w_idx] <= w_rr_next;
            r_resp_data <= mem_rdata_i;
            r_state     <= S_RESP;
          end else begin
            r_state <= S_MISS;
          end
        end
        S_STORE: begin
          if (mem_done_i) begin
            // A partial store miss leaves the array untouched: the rest of the word is unknown.
            if (w_hit) begin
              r_data[w_idx][w_hit_way] <= merge_bytes(r_data[w_idx][w_hit_way], r_wdata, r_be);
            end else if (r_be == 4'hF) begin
              r_valid[w_idx][w_victim] <= 1'b1;
              r_tag[w_idx][w_victim]   <= w_tag;
              r_data[w_idx][w_victim]  <= r_wdata;
              if (!w_has_inv) r_rr[w_idx] <= w_rr_next;
            end else begin
              r_state <= S_STORE;
            end
            r_resp_data <= 32'h0000_0000;
            r_state     <= S_RESP;
          end else begin
            r_state <= S_STORE;
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready_o  = (r_state == S_IDLE);
  assign resp_valid_o = (r_state == S_RESP);
  assign resp_data_o  = r_resp_data;
  assign mem_req_o    = (r_state == S_MISS) || (r_state == S_STORE);
  assign mem_we_o     = (r_state == S_STORE);
  assign mem_addr_o   = {r_addr, 2'b00};
  assign mem_wdata_o  = (r_state == S_STORE) ? r_wdata : 32'h0000_0000;
  assign mem_be_o     = (r_state == S_STORE) ? r_be :
                        (r_state == S_MISS)  ? 4'hF : 4'h0;

endmodule

// File: tb/tb_dcache_assoc.sv
// Directed, table-driven bench for dcache_assoc (SETS=64, WAYS=2) with a small memory responder.
module tb_dcache_assoc;

  localparam int MEM_LAT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rdy = 1'b1;
  logic        flush_i = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic        req_we_i = 1'b0;
  logic [31:0] req_addr_i = 32'h0;
  logic [31:0] req_wdata_i = 32'h0;
  logic [3:0]  req_be_i = 4'h0;
  logic        resp_valid_o;
  logic [31:0] resp_data_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_be_o;
  logic        mem_done_i = 1'b0;
  logic [31:0] mem_rdata_i = 32'h0;

  dcache_assoc #(.SETS(64), .WAYS(2), .TAG_HI(17)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush_i(flush_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .req_be_i(req_be_i),
    .resp_valid_o(resp_valid_o), .resp_data_o(resp_data_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o),
    .mem_done_i(mem_done_i), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        flush;
    logic        stall;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_data;
    logic        exp_mem;
    int          exp_lat;
  } vec_t;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] mem_model [logic [31:0]];
  vec_t vecs [19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic fl, input logic st, input logic we,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [3:0] be, input logic [31:0] exp_data,
                              input logic exp_mem, input int exp_lat);
    vec_t v;
    v.flush = fl; v.stall = st; v.we = we; v.addr = addr; v.wdata = wdata;
    v.be = be; v.exp_data = exp_data; v.exp_mem = exp_mem; v.exp_lat = exp_lat;
    return v;
  endfunction

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return 32'h0000_0000;
  endfunction

  task automatic do_flush();
    @(negedge clk);
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
  endtask

  // Issue one request and act as memory until the response; returns what was observed.
  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, input logic stall,
                        output logic [31:0] rdata, output int cycles, output logic saw_mem,
                        output logic [31:0] maddr, output logic mwe, output logic [3:0] mbe,
                        output logic timeout);
    int n;
    int wait_c;
    logic stalled;
    logic [31:0] old;
    @(negedge clk);
    req_valid_i = 1'b1; req_we_i = we; req_addr_i = addr; req_wdata_i = wdata; req_be_i = be;
    @(negedge clk);
    req_valid_i = 1'b0;
    n = 1; wait_c = 0; saw_mem = 1'b0; stalled = 1'b0; timeout = 1'b1;
    rdata = 32'h0; maddr = 32'h0; mwe = 1'b0; mbe = 4'h0;
    while (n < 200) begin
      if (resp_valid_o) begin
        rdata = resp_data_o;
        timeout = 1'b0;
        break;
      end
      mem_done_i = 1'b0;
      if (mem_req_o) begin
        if (!saw_mem) begin
          saw_mem = 1'b1; maddr = mem_addr_o; mwe = mem_we_o; mbe = mem_be_o;
        end
        if (stall && !stalled) begin
          rdy = 1'b0;
          repeat (3) begin
            @(negedge clk);
            n++;
            chk("stall_mem_req", {31'h0, mem_req_o}, 32'h1);
            chk("stall_mem_addr", mem_addr_o, maddr);
          end
          rdy = 1'b1;
          stalled = 1'b1;
        end
        wait_c++;
        if (wait_c == MEM_LAT) begin
          mem_done_i = 1'b1;
          mem_rdata_i = mem_rd(mem_addr_o);
          if (mem_we_o) begin
            old = mem_rd(mem_addr_o);
            for (int b = 0; b < 4; b++)
              if (mem_be_o[b]) old[8*b +: 8] = mem_wdata_o[8*b +: 8];
            mem_model[mem_addr_o] = old;
          end
        end
      end
      @(negedge clk);
      n++;
    end
    mem_done_i = 1'b0;
    cycles = n;
  endtask

  initial begin
    logic [31:0] rdata, maddr;
    int cycles;
    logic saw_mem, mwe, timeout, seen_resp;
    logic [3:0] mbe;

    mem_model[32'h0000_0000] = 32'h1000_0000;
    mem_model[32'h0000_0100] = 32'hDEAD_BEEF;
    mem_model[32'h0000_0200] = 32'h2000_0000;
    mem_model[32'h0000_0300] = 32'h3000_0000;
    mem_model[32'h0000_0040] = 32'h1122_3344;
    mem_model[32'h0000_0080] = 32'h5566_7788;
    mem_model[32'h0000_0084] = 32'h9999_9999;

    vecs[0]  = mk(0, 0, 0, 32'h100, 32'h0, 4'h0, 32'hDEAD_BEEF, 1, 4);
    vecs[1]  = mk(0, 0, 0, 32'h100, 32'h0, 4'h0, 32'hDEAD_BEEF, 0, 2);
    vecs[2]  = mk(1, 0, 0, 32'h100, 32'h0, 4'h0, 32'hDEAD_BEEF, 1, 4);
    vecs[3]  = mk(1, 0, 0, 32'h000, 32'h0, 4'h0, 32'h1000_0000, 1, 4);
    vecs[4]  = mk(0, 0, 0, 32'h100, 32'h0, 4'h0, 32'hDEAD_BEEF, 1, 4);
    vecs[5]  = mk(0, 0, 0, 32'h200, 32'h0, 4'h0, 32'h2000_0000, 1, 4);
    vecs[6]  = mk(0, 0, 0, 32'h103, 32'h0, 4'h0, 32'hDEAD_BEEF, 0, 2);
    vecs[7]  = mk(0, 0, 0, 32'h000, 32'h0, 4'h0, 32'h1000_0000, 1, 4);
    vecs[8]  = mk(0, 0, 0, 32'h200, 32'h0, 4'h0, 32'h2000_0000, 0, 2);
    vecs[9]  = mk(0, 0, 0, 32'h040, 32'h0, 4'h0, 32'h1122_3344, 1, 4);
    vecs[10] = mk(0, 0, 1, 32'h040, 32'h0000_AA00, 4'b0010, 32'h0, 1, 4);
    vecs[11] = mk(0, 0, 0, 32'h040, 32'h0, 4'h0, 32'h1122_AA44, 0, 2);
    vecs[12] = mk(0, 0, 1, 32'h080, 32'h0000_00EE, 4'b0001, 32'h0, 1, 4);
    vecs[13] = mk(0, 0, 0, 32'h080, 32'h0, 4'h0, 32'h5566_77EE, 1, 4);
    vecs[14] = mk(0, 0, 1, 32'h084, 32'hCAFE_F00D, 4'hF, 32'h0, 1, 4);
    vecs[15] = mk(0, 0, 0, 32'h084, 32'h0, 4'h0, 32'hCAFE_F00D, 0, 2);
    vecs[16] = mk(0, 0, 1, 32'h084, 32'h1200_0000, 4'b1000, 32'h0, 1, 4);
    vecs[17] = mk(0, 0, 0, 32'h084, 32'h0, 4'h0, 32'h12FE_F00D, 0, 2);
    vecs[18] = mk(1, 1, 0, 32'h100, 32'h0, 4'h0, 32'hDEAD_BEEF, 1, 7);

    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_req_ready", {31'h0, req_ready_o}, 32'h1);
    chk("rst_resp_valid", {31'h0, resp_valid_o}, 32'h0);
    chk("rst_resp_data", resp_data_o, 32'h0);
    chk("rst_mem_req", {31'h0, mem_req_o}, 32'h0);
    chk("rst_mem_sig", {mem_addr_o[31:5], mem_we_o, mem_be_o}, 32'h0);
    chk("rst_mem_wdata", mem_wdata_o, 32'h0);

    for (int i = 0; i < 19; i++) begin
      if (vecs[i].flush) do_flush();
      do_req(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be, vecs[i].stall,
             rdata, cycles, saw_mem, maddr, mwe, mbe, timeout);
      chk($sformatf("v%0d_timeout", i), {31'h0, timeout}, 32'h0);
      chk($sformatf("v%0d_data", i), rdata, vecs[i].exp_data);
      chk($sformatf("v%0d_latency", i), cycles, vecs[i].exp_lat);
      chk($sformatf("v%0d_mem_seen", i), {31'h0, saw_mem}, {31'h0, vecs[i].exp_mem});
      if (vecs[i].exp_mem && saw_mem) begin
        chk($sformatf("v%0d_mem_addr", i), maddr, {vecs[i].addr[31:2], 2'b00});
        chk($sformatf("v%0d_mem_we", i), {31'h0, mwe}, {31'h0, vecs[i].we});
        chk($sformatf("v%0d_mem_be", i), {28'h0, mbe}, {28'h0, (vecs[i].we ? vecs[i].be : 4'hF)});
      end
    end

    // Reset in the middle of a miss: idle next cycle, no response afterwards.
    @(negedge clk);
    req_valid_i = 1'b1; req_we_i = 1'b0; req_addr_i = 32'h300;
    @(negedge clk);
    req_valid_i = 1'b0;
    @(negedge clk);
    chk("rstmiss_mem_req_before", {31'h0, mem_req_o}, 32'h1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstmiss_ready", {31'h0, req_ready_o}, 32'h1);
    chk("rstmiss_mem_req", {31'h0, mem_req_o}, 32'h0);
    seen_resp = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (resp_valid_o || mem_req_o) seen_resp = 1'b1;
    end
    chk("rstmiss_no_resp", {31'h0, seen_resp}, 32'h0);
    do_req(1'b0, 32'h100, 32'h0, 4'h0, 1'b0, rdata, cycles, saw_mem, maddr, mwe, mbe, timeout);
    chk("rstmiss_reload_data", rdata, 32'hDEAD_BEEF);
    chk("rstmiss_reload_miss", {31'h0, saw_mem}, 32'h1);

    // A stray mem_done_i in IDLE must do nothing.
    @(negedge clk);
    mem_done_i = 1'b1; mem_rdata_i = 32'hFFFF_FFFF;
    @(negedge clk);
    mem_done_i = 1'b0;
    chk("stray_done_resp", {31'h0, resp_valid_o}, 32'h0);
    chk("stray_done_ready", {31'h0, req_ready_o}, 32'h1);
    do_req(1'b0, 32'h100, 32'h0, 4'h0, 1'b0, rdata, cycles, saw_mem, maddr, mwe, mbe, timeout);
    chk("stray_done_hit_data", rdata, 32'hDEAD_BEEF);
    chk("stray_done_hit_lat", cycles, 2);

    // Flush wins over a simultaneous request, which is not accepted.
    @(negedge clk);
    flush_i = 1'b1; req_valid_i = 1'b1; req_we_i = 1'b0; req_addr_i = 32'h100;
    @(negedge clk);
    flush_i = 1'b0; req_valid_i = 1'b0;
    chk("flush_req_ready", {31'h0, req_ready_o}, 32'h1);
    @(negedge clk);
    chk("flush_req_no_resp", {31'h0, resp_valid_o | mem_req_o}, 32'h0);
    do_req(1'b0, 32'h100, 32'h0, 4'h0, 1'b0, rdata, cycles, saw_mem, maddr, mwe, mbe, timeout);
    chk("flush_reload_miss", {31'h0, saw_mem}, 32'h1);
    chk("flush_reload_lat", cycles, 4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
